ram_ctrl: RTL

Sequencing controller upstream of the single-port `ram`. Accepts read/write requests on a valid/ready interface and converts them into `ram` bus cycles: `write`, `address`, and a shared bidirectional `data` line. Returns read data on a valid/ready response channel. Guarantees the shared `data` line has exactly one driver at any time.

---
 rtl/ram_pkg.sv | 17 +
 rtl/ram_bus_drv.sv | 17 +
 rtl/ram_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/ram_pkg.sv
// Shared definitions for the ram controller and the ram itself:
// controller state encoding and the default bus widths.
package ram_pkg;

    localparam int RAM_ADDR_WIDTH = 2;
    localparam int RAM_DATA_WIDTH = 1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WR        = 3'd1,
        RD_ADDR   = 3'd2,
        RD_SAMPLE = 3'd3,
        RSP       = 3'd4,
        INIT      = 3'd5
    } ram_state_e;

endpackage

// File: rtl/ram_bus_drv.sv
// Tristate driver for the shared ram data line; the only place that
// touches the inout, so the line has exactly one controller-side driver.
module ram_bus_drv
    import ram_pkg::*;
#(
    parameter int DATA_WIDTH = RAM_DATA_WIDTH
) (
    input  logic                  oe,
    input  logic [DATA_WIDTH-1:0] dout,
    output logic [DATA_WIDTH-1:0] din,
    inout  wire  [DATA_WIDTH-1:0] data
);

    assign data = oe ? dout : {DATA_WIDTH{1'bz}};
    assign din  = data;

endmodule

// File: rtl/ram_ctrl.sv
// Request/response sequencer in front of the single-port ram.
// Build option RAM_CTRL_INIT_EN adds a zero-fill of the whole ram after reset.
module ram_ctrl
    import ram_pkg::*;
#(
    parameter int ADDR_WIDTH = RAM_ADDR_WIDTH,
    parameter int DATA_WIDTH = RAM_DATA_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  write,
    output logic [ADDR_WIDTH-1:0] address,
    inout  wire  [DATA_WIDTH-1:0] data
);

    localparam logic [2:0] S_IDLE      = IDLE;
    localparam logic [2:0] S_WR        = WR;
    localparam logic [2:0] S_RD_ADDR   = RD_ADDR;
    localparam logic [2:0] S_RD_SAMPLE = RD_SAMPLE;
    localparam logic [2:0] S_RSP       = RSP;

`ifdef RAM_CTRL_INIT_EN
    localparam logic [2:0]            S_INIT    = INIT;
    localparam logic [ADDR_WIDTH-1:0] INIT_LAST = {ADDR_WIDTH{1'b1}};

    logic [ADDR_WIDTH-1:0] init_cnt;
`endif

    logic [2:0]            state;
    logic                  drive_en;
    logic [DATA_WIDTH-1:0] drive_val;
    logic [DATA_WIDTH-1:0] bus_val;

    ram_bus_drv #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_bus_drv (
        .oe   (drive_en),
        .dout (drive_val),
        .din  (bus_val),
        .data (data)
    );

    // Every output is a flop loaded with the value for the state being entered,
    // so nothing on the request or response side reaches an output combinationally.
    always_ff @(posedge clock) begin
        if (reset) begin
`ifdef RAM_CTRL_INIT_EN
            state    <= S_INIT;
            init_cnt <= '0;
`else
            state    <= S_IDLE;
`endif
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            write     <= 1'b0;
            address   <= '0;
            drive_en  <= 1'b0;
            drive_val <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    write    <= 1'b0;
                    drive_en <= 1'b0;
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        address   <= req_addr;
                        drive_val <= req_wdata;
                        if (req_write) begin
                            state    <= S_WR;
                            write    <= 1'b1;
                            drive_en <= 1'b1;
                        end else begin
                            state <= S_RD_ADDR;
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end

                S_WR: begin
                    state     <= S_IDLE;
                    write     <= 1'b0;
                    drive_en  <= 1'b0;
                    req_ready <= 1'b1;
                end

                S_RD_ADDR: begin
                    state <= S_RD_SAMPLE;
                end

                S_RD_SAMPLE: begin
                    state     <= S_RSP;
                    rsp_data  <= bus_val;
                    rsp_valid <= 1'b1;
                end

                S_RSP: begin
                    if (rsp_valid && rsp_ready) begin
                        state     <= S_IDLE;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end

`ifdef RAM_CTRL_INIT_EN
                // The counter simply wraps; leaving on the last address is the only exit.
                S_INIT: begin
                    write     <= 1'b1;
                    drive_en  <= 1'b1;
                    drive_val <= '0;
                    address   <= init_cnt;
                    init_cnt  <= init_cnt + 1'b1;
                    if (init_cnt == INIT_LAST) begin
                        state <= S_IDLE;
                    end
                end
`endif

                default: begin
                    state     <= S_IDLE;
                    write     <= 1'b0;
                    drive_en  <= 1'b0;
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
